// File: rtl/network_injector_pkg.sv
// Shared types and helpers for the message-to-flit injector.
//   flit_type_e : encoding of the flit_type sideband on the NoC link
//   state_e     : handshake FSM states of network_injector
//   calc_num_flits() : flits needed to carry one message
package network_injector_pkg;

    typedef enum logic [1:0] {
        HEADER      = 2'b00,
        BODY        = 2'b01,
        TAIL        = 2'b10,
        HEADER_TAIL = 2'b11
    } flit_type_e;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    // ceil(msg_width / flit_width)
    function automatic int unsigned calc_num_flits(input int unsigned msg_width,
                                                   input int unsigned flit_width);
        return (msg_width + flit_width - 1) / flit_width;
    endfunction

endpackage

// File: rtl/network_flit_serializer.sv
// Holds one captured message and walks it out flit by flit.
// Ports:
//   clk_i, rst_ni     : clock, synchronous active-low reset
//   load_i            : capture msg_data_i and restart at flit 0
//   next_i            : current flit was transferred; advance (wraps to 0 after last)
//   msg_data_i        : message payload to capture
//   flit_o            : current flit data (zero-padded above MessageWidth)
//   flit_type_o       : HEADER/BODY/TAIL/HEADER_TAIL of the current flit
//   last_o            : current flit is the final flit of the message
module network_flit_serializer
    import network_injector_pkg::*;
#(
    parameter int unsigned FlitWidth     = 64,
    parameter int unsigned FlitTypeWidth = 2,
    parameter int unsigned MessageWidth  = 256
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     load_i,
    input  logic                     next_i,
    input  logic [MessageWidth-1:0]  msg_data_i,
    output logic [FlitWidth-1:0]     flit_o,
    output logic [FlitTypeWidth-1:0] flit_type_o,
    output logic                     last_o
);

    localparam int unsigned NumFlits = calc_num_flits(MessageWidth, FlitWidth);
    localparam int unsigned IdxWidth = (NumFlits > 1) ? $clog2(NumFlits) : 1;
    localparam int unsigned PadWidth = NumFlits * FlitWidth;
    localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumFlits - 1);

    logic [PadWidth-1:0] msg_q, msg_d;
    logic [IdxWidth-1:0] idx_q, idx_d;
    logic [1:0]          ftype;

    assign last_o = (idx_q == LastIdx);

    always_comb begin
        msg_d = msg_q;
        idx_d = idx_q;
        if (load_i) begin
            // Zero-extension pads the final flit above MessageWidth.
            msg_d = PadWidth'(msg_data_i);
            idx_d = '0;
        end else if (next_i) begin
            idx_d = last_o ? '0 : idx_q + IdxWidth'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            msg_q <= '0;
            idx_q <= '0;
        end else begin
            msg_q <= msg_d;
            idx_q <= idx_d;
        end
    end

    assign flit_o = msg_q[32'(idx_q) * FlitWidth +: FlitWidth];

    always_comb begin
        ftype = BODY;
        if (NumFlits == 1) begin
            ftype = HEADER_TAIL;
        end else if (idx_q == '0) begin
            ftype = HEADER;
        end else if (last_o) begin
            ftype = TAIL;
        end
    end

    assign flit_type_o = FlitTypeWidth'(ftype);

endmodule

// File: rtl/network_injector.sv
// Message-to-flit injector: accepts one wide message per ready/valid handshake and
// drives its flits onto the NoC flit link, honouring the ready of the target VN.
// Ports:
//   clk, rst            : clock, synchronous active-low reset
//   msg_valid/msg_ready : message handshake (msg_ready combinational from ready)
//   msg_data            : message payload, flit k = msg_data[k*FlitWidth +: FlitWidth]
//   msg_broadcast       : broadcast sideband, held for the whole message
//   msg_vn              : target VN; out-of-range VNs are dropped with err_vn
//   err_vn              : one-cycle pulse after an out-of-range message is dropped
//   valid/ready         : flit handshake, transfer = valid & ready[virtual_identifier]
//   flit, flit_type     : flit data and type
//   broadcast, virtual_identifier : per-message sideband
module network_injector
    import network_injector_pkg::*;
#(
    parameter int unsigned FlitWidth                         = 64,
    parameter int unsigned FlitTypeWidth                     = 2,
    parameter int unsigned BroadcastWidth                    = 1,
    parameter int unsigned VirtualNetworkOrChannelIdWidth    = 2,
    parameter int unsigned NumberOfVirtualNetworksOrChannels = 3,
    parameter int unsigned MessageWidth                      = 256
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      msg_valid,
    output logic                                      msg_ready,
    input  logic [MessageWidth-1:0]                   msg_data,
    input  logic [BroadcastWidth-1:0]                 msg_broadcast,
    input  logic [VirtualNetworkOrChannelIdWidth-1:0] msg_vn,
    output logic                                      err_vn,
    output logic                                      valid,
    input  logic [NumberOfVirtualNetworksOrChannels-1:0] ready,
    output logic [FlitWidth-1:0]                      flit,
    output logic [FlitTypeWidth-1:0]                  flit_type,
    output logic [BroadcastWidth-1:0]                 broadcast,
    output logic [VirtualNetworkOrChannelIdWidth-1:0] virtual_identifier
);

    if (FlitTypeWidth < 2) begin : gen_chk_ftw
        $error("FlitTypeWidth must be at least 2");
    end
    if (NumberOfVirtualNetworksOrChannels > (2 ** VirtualNetworkOrChannelIdWidth)) begin : gen_chk_vn
        $error("NumberOfVirtualNetworksOrChannels exceeds the VN identifier range");
    end

    state_e state_q, state_d;
    logic [BroadcastWidth-1:0]                 bc_q, bc_d;
    logic [VirtualNetworkOrChannelIdWidth-1:0] vi_q, vi_d;
    logic                                      err_q, err_d;

    logic                     vn_ok, accept, load, transfer;
    logic                     ser_last;
    logic [FlitWidth-1:0]     ser_flit;
    logic [FlitTypeWidth-1:0] ser_type;

    assign vn_ok    = (32'(msg_vn) < NumberOfVirtualNetworksOrChannels);
    assign transfer = (state_q == SEND) & ready[vi_q];
    // Accepting during the last-flit transfer gives back-to-back messages with no bubble.
    assign msg_ready = rst & ((state_q == IDLE) | (transfer & ser_last));
    assign accept    = msg_valid & msg_ready;
    assign load      = accept & vn_ok;

    always_comb begin
        state_d = state_q;
        bc_d    = bc_q;
        vi_d    = vi_q;
        err_d   = accept & ~vn_ok;
        unique case (state_q)
            IDLE: if (load) state_d = SEND;
            SEND: if (transfer & ser_last) state_d = load ? SEND : IDLE;
            default: state_d = IDLE;
        endcase
        if (load) begin
            bc_d = msg_broadcast;
            vi_d = msg_vn;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            bc_q    <= '0;
            vi_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bc_q    <= bc_d;
            vi_q    <= vi_d;
            err_q   <= err_d;
        end
    end

    network_flit_serializer #(
        .FlitWidth     (FlitWidth),
        .FlitTypeWidth (FlitTypeWidth),
        .MessageWidth  (MessageWidth)
    ) u_serializer (
        .clk_i       (clk),
        .rst_ni      (rst),
        .load_i      (load),
        .next_i      (transfer),
        .msg_data_i  (msg_data),
        .flit_o      (ser_flit),
        .flit_type_o (ser_type),
        .last_o      (ser_last)
    );

    assign valid              = (state_q == SEND);
    // Idle outputs read as zero so a single-flit config does not show HEADER_TAIL in reset.
    assign flit               = valid ? ser_flit : '0;
    assign flit_type          = valid ? ser_type : '0;
    assign broadcast          = bc_q;
    assign virtual_identifier = vi_q;
    assign err_vn             = err_q;

endmodule

// File: tb/tb_network_injector.sv
module tb_network_injector;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Default configuration: 256-bit messages, 4 flits.
    logic         msg_valid, msg_ready;
    logic [255:0] msg_data;
    logic [0:0]   msg_broadcast;
    logic [1:0]   msg_vn;
    logic         err_vn, valid;
    logic [2:0]   ready;
    logic [63:0]  flit;
    logic [1:0]   flit_type;
    logic [0:0]   broadcast;
    logic [1:0]   virtual_identifier;

    // 48-bit messages: a single padded HEADER_TAIL flit.
    logic         s_msg_valid, s_msg_ready;
    logic [47:0]  s_msg_data;
    logic [0:0]   s_msg_broadcast;
    logic [1:0]   s_msg_vn;
    logic         s_err_vn, s_valid;
    logic [2:0]   s_ready;
    logic [63:0]  s_flit;
    logic [1:0]   s_flit_type;
    logic [0:0]   s_broadcast;
    logic [1:0]   s_virtual_identifier;

    int n_checks = 0;
    int n_pass   = 0;

    network_injector u_dut (
        .clk                (clk),
        .rst                (rst),
        .msg_valid          (msg_valid),
        .msg_ready          (msg_ready),
        .msg_data           (msg_data),
        .msg_broadcast      (msg_broadcast),
        .msg_vn             (msg_vn),
        .err_vn             (err_vn),
        .valid              (valid),
        .ready              (ready),
        .flit               (flit),
        .flit_type          (flit_type),
        .broadcast          (broadcast),
        .virtual_identifier (virtual_identifier)
    );

    network_injector #(
        .MessageWidth (48)
    ) u_small (
        .clk                (clk),
        .rst                (rst),
        .msg_valid          (s_msg_valid),
        .msg_ready          (s_msg_ready),
        .msg_data           (s_msg_data),
        .msg_broadcast      (s_msg_broadcast),
        .msg_vn             (s_msg_vn),
        .err_vn             (s_err_vn),
        .valid              (s_valid),
        .ready              (s_ready),
        .flit               (s_flit),
        .flit_type          (s_flit_type),
        .broadcast          (s_broadcast),
        .virtual_identifier (s_virtual_identifier)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        msg_valid = 1'b1;
        ready = 3'b111;
        s_msg_valid = 1'b1;
        s_ready = 3'b111;
        step();
        step();
        n_checks++;
        if ({valid, flit, flit_type, broadcast, virtual_identifier, err_vn} !== '0)
            $display("FAIL reset_outputs: got valid=%0b flit=%h type=%0d bc=%0b vi=%0d err=%0b want all 0",
                     valid, flit, flit_type, broadcast, virtual_identifier, err_vn);
        else n_pass++;
        n_checks++;
        if (msg_ready !== 1'b0) $display("FAIL reset_msg_ready: got %0b want 0", msg_ready);
        else n_pass++;
        n_checks++;
        if ({s_valid, s_flit, s_flit_type, s_msg_ready} !== '0)
            $display("FAIL reset_small: got valid=%0b flit=%h type=%0d msg_ready=%0b want all 0",
                     s_valid, s_flit, s_flit_type, s_msg_ready);
        else n_pass++;
        msg_valid = 1'b0;
        s_msg_valid = 1'b0;
        rst = 1'b1;
        step();
        n_checks++;
        if (msg_ready !== 1'b1 || valid !== 1'b0)
            $display("FAIL idle_after_reset: got msg_ready=%0b valid=%0b want 1 0", msg_ready, valid);
        else n_pass++;
    endtask

    task automatic test_stream();
        logic [1:0] exp_t [4] = '{2'b00, 2'b01, 2'b01, 2'b10};
        ready = 3'b010;
        msg_vn = 2'd1;
        msg_broadcast = 1'b0;
        msg_data = {64'd4, 64'd3, 64'd2, 64'd1};
        msg_valid = 1'b1;
        n_checks++;
        if (msg_ready !== 1'b1 || valid !== 1'b0)
            $display("FAIL stream_accept: got msg_ready=%0b valid=%0b want 1 0", msg_ready, valid);
        else n_pass++;
        step();
        msg_valid = 1'b0;
        msg_data = '1;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (valid !== 1'b1 || flit !== 64'(k + 1) || flit_type !== exp_t[k] ||
                virtual_identifier !== 2'd1)
                $display("FAIL stream_flit%0d: got valid=%0b flit=%h type=%0d vi=%0d want 1 %h %0d 1",
                         k, valid, flit, flit_type, virtual_identifier, 64'(k + 1), exp_t[k]);
            else n_pass++;
            step();
        end
        n_checks++;
        if (valid !== 1'b0) $display("FAIL stream_done: got valid=%0b want 0", valid);
        else n_pass++;
    endtask

    task automatic test_stall();
        logic [1:0] exp_t [4] = '{2'b00, 2'b01, 2'b01, 2'b10};
        int idx = 0;
        int errs = 0;
        msg_data = {64'd4, 64'd3, 64'd2, 64'd1};
        msg_vn = 2'd1;
        msg_valid = 1'b1;
        ready = 3'b101;
        step();
        msg_valid = 1'b0;
        for (int c = 0; c < 20 && idx < 4; c++) begin
            ready = c[0] ? 3'b111 : 3'b101;
            if (valid !== 1'b1 || flit !== 64'(idx + 1) || flit_type !== exp_t[idx]) begin
                $display("FAIL stall_cycle%0d: got valid=%0b flit=%h type=%0d want 1 %h %0d",
                         c, valid, flit, flit_type, 64'(idx + 1), exp_t[idx]);
                errs++;
            end
            if (ready[1]) idx++;
            step();
        end
        n_checks++;
        if (errs != 0) $display("FAIL stall_hold: got %0d bad cycles want 0", errs);
        else n_pass++;
        n_checks++;
        if (idx != 4) $display("FAIL stall_timeout: got %0d transfers want 4", idx);
        else n_pass++;
        ready = 3'b111;
        step();
        n_checks++;
        if (valid !== 1'b0) $display("FAIL stall_no_extra: got valid=%0b want 0", valid);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp_f [8] = '{64'h1, 64'h2, 64'h3, 64'h4, 64'h11, 64'h12, 64'h13, 64'h14};
        logic [1:0]  exp_t [4] = '{2'b00, 2'b01, 2'b01, 2'b10};
        logic        exp_r;
        ready = 3'b010;
        msg_vn = 2'd1;
        msg_data = {64'd4, 64'd3, 64'd2, 64'd1};
        msg_valid = 1'b1;
        step();
        msg_data = {64'h14, 64'h13, 64'h12, 64'h11};
        for (int k = 0; k < 8; k++) begin
            exp_r = (k == 3) || (k == 7);
            n_checks++;
            if (valid !== 1'b1 || flit !== exp_f[k] || flit_type !== exp_t[k % 4] ||
                msg_ready !== exp_r)
                $display("FAIL b2b_flit%0d: got valid=%0b flit=%h type=%0d msg_ready=%0b want 1 %h %0d %0b",
                         k, valid, flit, flit_type, msg_ready, exp_f[k], exp_t[k % 4], exp_r);
            else n_pass++;
            step();
            if (k == 3) msg_valid = 1'b0;
        end
        n_checks++;
        if (valid !== 1'b0) $display("FAIL b2b_done: got valid=%0b want 0", valid);
        else n_pass++;
    endtask

    task automatic test_single();
        s_msg_data = 48'hABCD_EF12_3456;
        s_msg_vn = 2'd0;
        s_msg_broadcast = 1'b1;
        s_ready = 3'b001;
        s_msg_valid = 1'b1;
        step();
        s_msg_valid = 1'b0;
        n_checks++;
        if (s_valid !== 1'b1 || s_flit !== 64'h0000_ABCD_EF12_3456 || s_flit_type !== 2'b11 ||
            s_broadcast !== 1'b1 || s_msg_ready !== 1'b1)
            $display("FAIL single_flit: got valid=%0b flit=%h type=%0d bc=%0b msg_ready=%0b want 1 0000abcdef123456 3 1 1",
                     s_valid, s_flit, s_flit_type, s_broadcast, s_msg_ready);
        else n_pass++;
        step();
        n_checks++;
        if (s_valid !== 1'b0) $display("FAIL single_done: got valid=%0b want 0", s_valid);
        else n_pass++;
    endtask

    task automatic test_bad_vn();
        ready = 3'b111;
        msg_vn = 2'd3;
        msg_valid = 1'b1;
        n_checks++;
        if (msg_ready !== 1'b1) $display("FAIL badvn_accept: got msg_ready=%0b want 1", msg_ready);
        else n_pass++;
        step();
        msg_valid = 1'b0;
        msg_vn = 2'd1;
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if (err_vn !== (c == 0) || valid !== 1'b0)
                $display("FAIL badvn_cycle%0d: got err_vn=%0b valid=%0b want %0b 0",
                         c, err_vn, valid, (c == 0));
            else n_pass++;
            step();
        end
    endtask

    task automatic test_reset_mid();
        ready = 3'b010;
        msg_vn = 2'd1;
        msg_broadcast = 1'b1;
        msg_data = {64'd4, 64'd3, 64'd2, 64'd1};
        msg_valid = 1'b1;
        step();
        msg_valid = 1'b0;
        step();
        step();
        n_checks++;
        if (valid !== 1'b1 || flit !== 64'd3)
            $display("FAIL rmid_pre: got valid=%0b flit=%h want 1 3", valid, flit);
        else n_pass++;
        rst = 1'b0;
        step();
        n_checks++;
        if ({valid, flit, flit_type, broadcast, virtual_identifier, msg_ready} !== '0)
            $display("FAIL rmid_reset: got valid=%0b flit=%h type=%0d bc=%0b vi=%0d msg_ready=%0b want all 0",
                     valid, flit, flit_type, broadcast, virtual_identifier, msg_ready);
        else n_pass++;
        rst = 1'b1;
        ready = 3'b100;
        msg_vn = 2'd2;
        msg_data = {64'd8, 64'd7, 64'd6, 64'd5};
        msg_valid = 1'b1;
        step();
        msg_valid = 1'b0;
        n_checks++;
        if (valid !== 1'b1 || flit !== 64'd5 || flit_type !== 2'b00 ||
            virtual_identifier !== 2'd2 || broadcast !== 1'b1)
            $display("FAIL rmid_restart: got valid=%0b flit=%h type=%0d vi=%0d bc=%0b want 1 5 0 2 1",
                     valid, flit, flit_type, virtual_identifier, broadcast);
        else n_pass++;
        for (int c = 0; c < 4; c++) step();
        n_checks++;
        if (valid !== 1'b0) $display("FAIL rmid_done: got valid=%0b want 0", valid);
        else n_pass++;
    endtask

    initial begin
        msg_valid = 1'b0;
        msg_data = '0;
        msg_broadcast = '0;
        msg_vn = '0;
        ready = '0;
        s_msg_valid = 1'b0;
        s_msg_data = '0;
        s_msg_broadcast = '0;
        s_msg_vn = '0;
        s_ready = '0;
        test_reset();
        test_stream();
        test_stall();
        test_back_to_back();
        test_single();
        test_bad_vn();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/network_injector.md
# network_injector

Message-to-flit injector on the network side of a tile: accepts one wide message per handshake, segments it into FlitWidth-sized flits (header/body/tail) and drives them onto the NoC ready/valid flit interface. It is the transmitting end of the flit link consumed by the network ejector. Per-virtual-network ready is honoured, and broadcast/virtual-identifier sideband is held constant for the whole message.

## Interface
Parameters:
- FlitWidth, 64: flit data width.
- FlitTypeWidth, 2: flit type width; must be ≥ 2.
- BroadcastWidth, 1: broadcast sideband width.
- VirtualNetworkOrChannelIdWidth, 2: VN/VC identifier width.
- NumberOfVirtualNetworksOrChannels, 3: number of VNs; width of `ready`.
- MessageWidth, 256: input message width.
- Derived NumFlits = ceil(MessageWidth/FlitWidth): flits per message, ≥ 1.

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous active-low reset.
- msg_valid  in  1  message offered.
- msg_ready  out  1  message accepted when msg_valid & msg_ready.
- msg_data  in  MessageWidth  message payload; bits [FlitWidth-1:0] form the header flit.
- msg_broadcast  in  BroadcastWidth  broadcast sideband for the message.
- msg_vn  in  VirtualNetworkOrChannelIdWidth  target virtual network.
- err_vn  out  1  one-cycle pulse when a message with an out-of-range VN is dropped.
- valid  out  1  flit valid.
- ready  in  NumberOfVirtualNetworksOrChannels  per-VN ready from the NoC.
- flit  out  FlitWidth  flit data.
- flit_type  out  FlitTypeWidth  flit type.
- broadcast  out  BroadcastWidth  broadcast sideband.
- virtual_identifier  out  VirtualNetworkOrChannelIdWidth  VN of the current flit.

## Operation
- Flit transfer: valid & ready[virtual_identifier]. No other condition transfers a flit.
- Once valid rises, valid, flit, flit_type, broadcast and virtual_identifier stay stable until the transfer.
- Message capture: msg_data, msg_broadcast and msg_vn are registered on acceptance. The input may change afterwards.
- Flit k carries msg_data[k*FlitWidth +: FlitWidth]. The last flit is zero-padded above MessageWidth.
- flit_type encoding:
  - NumFlits = 1: the single flit is HEADER_TAIL.
  - Otherwise: flit 0 is HEADER, flits 1..NumFlits-2 are BODY, and the last flit is TAIL.
- States:
  - IDLE: valid = 0 and msg_ready = 1. On acceptance with msg_vn < NumberOfVirtualNetworksOrChannels, go to SEND with flit index 0. On acceptance with an out-of-range VN, pulse err_vn next cycle, emit no flits and stay in IDLE.
  - SEND: valid = 1. Each transfer increments the flit index. A transfer of the last flit returns to IDLE, unless a new message is accepted in the same cycle.
- msg_ready = (state == IDLE) | (SEND & transfer & last flit). This is a combinational path from ready. It allows back-to-back messages with no bubble.
- Simultaneous last-flit transfer and valid new message: the next cycle shows the new message's flit 0 with valid = 1.
- Simultaneous last-flit transfer and accepted out-of-range message: go to IDLE and pulse err_vn.
- Ready of VNs other than virtual_identifier is ignored.

## Timing
- Reset (rst = 0 at a rising edge), on the next cycle:
  - valid = 0, flit = 0, flit_type = 0, broadcast = 0, virtual_identifier = 0.
  - err_vn = 0, msg_ready = 0, state = IDLE, flit index = 0.
- msg_ready is forced to 0 while rst = 0.
- Reset mid-message: the remaining flits are discarded, and valid = 0 the cycle after reset asserts.
- Latency: message accepted at edge N drives flit 0 valid in cycle N+1.
- Throughput: one flit per cycle with continuous ready, so NumFlits cycles per message.
- Stall: ready[vn] low holds the outputs indefinitely. There is no timeout.
- The flit index counter is max(1, $clog2(NumFlits)) bits wide and never exceeds NumFlits-1.

## Structure
- Package network_injector_pkg:
  - flit type enum: HEADER = 2'b00, BODY = 2'b01, TAIL = 2'b10, HEADER_TAIL = 2'b11.
  - NumFlits computation function.
  - state enum {IDLE, SEND}.
- One natural sub-module: network_flit_serializer. It holds the message register, flit index and flit_type/last generation. The top level keeps the handshake FSM and VN range check.
- Elaboration assertions:
  - FlitTypeWidth ≥ 2.
  - NumberOfVirtualNetworksOrChannels ≤ 2**VirtualNetworkOrChannelIdWidth.

## Test plan
- Defaults, message 256'h...04_03_02_01 (word k = k+1), msg_vn = 1, ready = 3'b010 held: 4 consecutive flits 1, 2, 3, 4 with types HEADER, BODY, BODY, TAIL and virtual_identifier = 1; the first flit appears the cycle after acceptance.
- Same message with ready[1] toggling every cycle and ready[0], ready[2] held 1: each flit held stable while ready[1] = 0, exactly 4 transfers, no duplicates.
- Two messages offered back-to-back with continuous ready: 8 flits in 8 consecutive cycles, msg_ready high in the first message's TAIL transfer cycle.
- MessageWidth = 48, FlitWidth = 64: a single HEADER_TAIL flit with bits [63:48] = 0.
- msg_vn = 3 with 3 VNs: accepted, err_vn pulses exactly once, valid stays 0.
- rst = 0 after 2 of 4 flits transferred: valid = 0 next cycle, all outputs 0, and a new message after reset starts with a HEADER flit.
